// File: rtl/syscall_console_tx_pkg.sv
// syscall_console_tx_pkg: service codes, ASCII constants, powers of ten and FSM states
package syscall_console_tx_pkg;
    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_EXIT = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [31:0] POW10 [10] = '{
        32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000,
        32'd100000, 32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000
    };
    typedef enum logic [2:0] {IDLE, CONVERT, LOAD, START, DATA, STOP, HALTED} stateT;
endpackage

// File: rtl/syscall_console_tx_uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serializer; a start on the done cycle chains the next frame with no idle gap
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic          active;
    logic [9:0]    frame;
    logic [3:0]    bitIdx;
    logic [CW-1:0] clkCnt;
    assign done = active && bitIdx == 4'd9 && clkCnt == LAST;
    assign tx = active ? frame[0] : 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            frame <= '1;
            bitIdx <= '0;
            clkCnt <= '0;
        end else if (start && (!active || done)) begin
            active <= 1'b1;
            frame <= {1'b1, data, 1'b0};
            bitIdx <= '0;
            clkCnt <= '0;
        end else if (done) begin
            active <= 1'b0;
        end else if (active && clkCnt == LAST) begin
            clkCnt <= '0;
            bitIdx <= bitIdx + 4'd1;
            frame <= {1'b1, frame[9:1]};
        end else if (active) begin
            clkCnt <= clkCnt + CW'(1);
        end
    end
endmodule

// File: rtl/syscall_console_tx.sv
// syscall_console_tx: services print-int/print-char/exit syscalls onto a UART console line
module syscall_console_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int BUF_DEPTH = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall_req,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        busy,
    output logic        tx,
    output logic        halt,
    output logic        bad_code,
    output logic [15:0] chars_sent
);
    import syscall_console_tx_pkg::*;
    localparam int PW = $clog2(10 * CLKS_PER_BIT + 1);
    localparam int AW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] START_END = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] DATA_END = PW'(9 * CLKS_PER_BIT - 1);
    stateT         state, stateNext;
    logic [7:0]    charBuf [BUF_DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [31:0]   rem;
    logic [3:0]    powIdx, digit;
    logic          started, accept, isInt, isChar, isExit, geq, emit, start, uartDone;
    logic [PW-1:0] phaseCnt;
    assign isInt = v0 == SYS_PRINT_INT;
    assign isChar = v0 == SYS_PRINT_CHAR;
    assign isExit = v0 == SYS_EXIT;
    assign accept = state == IDLE && syscall_req && !halt;
    assign geq = rem >= POW10[powIdx];
    // A digit is committed once the remainder drops below the current power; leading zeros are skipped
    assign emit = state == CONVERT && !geq && (digit != 4'd0 || started || powIdx == 4'd0);
    uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) uart (
        .clk(clk), .reset(reset), .start(start), .data(charBuf[rdPtr]), .tx(tx), .done(uartDone)
    );
    always_comb begin
        stateNext = state;
        start = 1'b0;
        case (state)
            IDLE: if (accept) stateNext = isInt ? CONVERT : isChar ? LOAD : isExit ? HALTED : IDLE;
            CONVERT: if (!geq && powIdx == 4'd0) stateNext = LOAD;
            LOAD: begin
                start = 1'b1;
                stateNext = START;
            end
            START: if (phaseCnt == START_END) stateNext = DATA;
            DATA: if (phaseCnt == DATA_END) stateNext = STOP;
            // Chaining the next pop on the stop bit's last cycle keeps frames back-to-back
            STOP: if (uartDone) begin
                start = rdPtr != wrPtr;
                stateNext = rdPtr != wrPtr ? START : IDLE;
            end
            HALTED: stateNext = HALTED;
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            halt <= 1'b0;
            bad_code <= 1'b0;
            chars_sent <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            rem <= '0;
            powIdx <= 4'd9;
            digit <= '0;
            started <= 1'b0;
            phaseCnt <= '0;
        end else begin
            state <= stateNext;
            busy <= stateNext inside {CONVERT, LOAD, START, DATA, STOP};
            halt <= halt || stateNext == HALTED;
            bad_code <= accept && !(isInt || isChar || isExit);
            phaseCnt <= start ? '0 : phaseCnt + PW'(1);
            if (uartDone) chars_sent <= chars_sent + 16'd1;
            if (accept) begin
                rdPtr <= '0;
                wrPtr <= (isChar || (isInt && a0[31])) ? AW'(1) : '0;
                rem <= a0[31] ? -a0 : a0;
                powIdx <= 4'd9;
                digit <= '0;
                started <= 1'b0;
            end else begin
                if (start) rdPtr <= rdPtr + AW'(1);
                if (emit) begin
                    wrPtr <= wrPtr + AW'(1);
                    started <= 1'b1;
                end
                if (state == CONVERT && geq) begin
                    rem <= rem - POW10[powIdx];
                    digit <= digit + 4'd1;
                end else if (state == CONVERT) begin
                    digit <= '0;
                    if (powIdx != 4'd0) powIdx <= powIdx - 4'd1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (accept) charBuf[0] <= isChar ? a0[7:0] : ASCII_MINUS;
        else if (emit) charBuf[wrPtr] <= ASCII_ZERO + {4'd0, digit};
    end
endmodule

// File: tb/tb_syscall_console_tx.sv
// tb_syscall_console_tx: vector table, random printf-model checks and hand-written corner sequences
module tb_syscall_console_tx;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic reset, syscall_req, busy, tx, halt, bad_code;
    logic [31:0] v0, a0;
    logic [15:0] chars_sent;
    syscall_console_tx #(.CLKS_PER_BIT(CPB), .BUF_DEPTH(11)) dut (
        .clk(clk), .reset(reset), .syscall_req(syscall_req), .v0(v0), .a0(a0),
        .busy(busy), .tx(tx), .halt(halt), .bad_code(bad_code), .chars_sent(chars_sent)
    );
    always #5 clk = ~clk;
    int cyc = 0, busyCnt = 0, txLowCnt = 0, badCnt = 0, rstCount = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge reset) rstCount <= rstCount + 1;
    always @(negedge clk) begin
        busyCnt <= busyCnt + int'(busy === 1'b1);
        txLowCnt <= txLowCnt + int'(tx === 1'b0);
        badCnt <= badCnt + int'(bad_code === 1'b1);
    end
    int nCmp = 0, nFail = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    // Line receiver: samples each bit mid-way and records every clean frame with its start cycle
    byte unsigned rxQ[$];
    int rxStartQ[$];
    int rxFrameErr = 0, rxSt, rxR0;
    logic [7:0] rxB;
    bit rxOk;
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                rxSt = cyc;
                rxR0 = rstCount;
                rxOk = 1'b1;
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0 || reset !== 1'b0) rxOk = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rxB[i] = tx;
                    if (reset !== 1'b0) rxOk = 1'b0;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1 || reset !== 1'b0) rxOk = 1'b0;
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
                if (rxOk && rxR0 == rstCount) begin
                    rxQ.push_back(rxB);
                    rxStartQ.push_back(rxSt);
                end else if (rxR0 == rstCount) rxFrameErr++;
            end
        end
    end
    byte unsigned expQ[$];
    function automatic void setExp(input string s);
        expQ.delete();
        foreach (s[i]) expQ.push_back(s[i]);
    endfunction
    function automatic void modelExp(input logic [31:0] c, input logic [31:0] arg);
        if (c == 32'd11) begin
            expQ.delete();
            expQ.push_back(arg[7:0]);
        end else setExp($sformatf("%0d", $signed(arg)));
    endfunction
    task automatic request(input logic [31:0] c, input logic [31:0] arg);
        @(negedge clk);
        v0 = c;
        a0 = arg;
        syscall_req = 1'b1;
        @(negedge clk);
        syscall_req = 1'b0;
        v0 = $urandom;
        a0 = $urandom;
    endtask
    task automatic sendAndCheck(input string name, input logic [31:0] c, input logic [31:0] arg);
        int base;
        bit timedOut;
        rxQ.delete();
        rxStartQ.delete();
        base = int'(chars_sent);
        timedOut = 1'b1;
        request(c, arg);
        check({name, " busy"}, busy, 1);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                timedOut = 1'b0;
                break;
            end
        end
        check({name, " done"}, timedOut, 0);
        repeat (2) @(negedge clk);
        check({name, " count"}, rxQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
            check($sformatf("%s char%0d", name, i), rxQ[i], expQ[i]);
            if (i > 0) check($sformatf("%s gap%0d", name, i), rxStartQ[i] - rxStartQ[i-1], 10 * CPB);
        end
        check({name, " chars_sent"}, int'(chars_sent) - base, expQ.size());
        check({name, " tx idle"}, tx, 1);
    endtask
    typedef struct {
        logic [31:0] v0;
        logic [31:0] a0;
        string exp;
    } vecT;
    vecT vecs [8];
    logic [9:0] aBits = 10'b1010000010;
    logic [CPB-1:0] s;
    logic [31:0] rc, ra;
    int b0, b1, b2, cs0;
    bit to;
    initial begin
        reset = 1'b1;
        syscall_req = 1'b0;
        v0 = '0;
        a0 = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset halt", halt, 0);
        check("reset bad_code", bad_code, 0);
        check("reset chars_sent", chars_sent, 0);
        reset = 1'b0;
        // Print 'A' bit by bit, with an ignored request for 'B' during the frame
        rxQ.delete();
        rxStartQ.delete();
        b0 = busyCnt;
        request(32'd11, 32'h41);
        check("A busy after accept", busy, 1);
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (tx === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("A start seen", to, 0);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                s[c] = tx;
                if (i == 2 && c == 0) begin
                    v0 = 32'd11;
                    a0 = 32'h42;
                    syscall_req = 1'b1;
                end else syscall_req = 1'b0;
                @(negedge clk);
            end
            check($sformatf("A bit%0d", i), s, {CPB{aBits[i]}});
        end
        check("A busy falls with stop", busy, 0);
        check("A busy length ok", (busyCnt - b0 > 40) && (busyCnt - b0 <= 44), 1);
        b1 = txLowCnt;
        repeat (60) @(negedge clk);
        check("B ignored tx", txLowCnt - b1, 0);
        check("A chars_sent", chars_sent, 1);
        check("A rx count", rxQ.size(), 1);
        if (rxQ.size() > 0) check("A rx byte", rxQ[0], 8'h41);
        vecs = '{
            '{32'd1, 32'h0, "0"},
            '{32'd1, 32'hFFFFFECF, "-305"},
            '{32'd1, 32'h80000000, "-2147483648"},
            '{32'd1, 32'h7FFFFFFF, "2147483647"},
            '{32'd11, 32'h7E, "~"},
            '{32'd1, 32'd42, "42"},
            '{32'd1, 32'hFFFFFFFF, "-1"},
            '{32'd1, 32'd1000000000, "1000000000"}
        };
        foreach (vecs[i]) begin
            setExp(vecs[i].exp);
            sendAndCheck($sformatf("vec%0d", i), vecs[i].v0, vecs[i].a0);
        end
        for (int r = 0; r < 10; r++) begin
            rc = ($urandom_range(0, 3) == 0) ? 32'd11 : 32'd1;
            ra = $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 99999));
            if (rc == 32'd1 && $urandom_range(0, 1) == 1) ra = -ra;
            modelExp(rc, ra);
            sendAndCheck($sformatf("rand%0d", r), rc, ra);
        end
        // Unsupported code: one bad_code pulse, nothing else moves
        b0 = busyCnt;
        b1 = txLowCnt;
        b2 = badCnt;
        cs0 = int'(chars_sent);
        request(32'd99, 32'd5);
        check("bad_code pulse", bad_code, 1);
        repeat (20) @(negedge clk);
        check("bad_code once", badCnt - b2, 1);
        check("bad busy", busyCnt - b0, 0);
        check("bad tx", txLowCnt - b1, 0);
        check("bad chars_sent", int'(chars_sent), cs0);
        check("bad halt", halt, 0);
        // Asynchronous reset during data bit 3
        request(32'd11, 32'h5A);
        for (int k = 0; k < 20 && tx !== 1'b0; k++) @(negedge clk);
        repeat (4 * CPB + 1) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset tx", tx, 1);
        check("midreset busy", busy, 0);
        check("midreset chars_sent", chars_sent, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        setExp("C");
        sendAndCheck("after reset", 32'd11, 32'h43);
        check("after reset chars_sent", chars_sent, 1);
        // Exit, then a print request that must be ignored
        request(32'd10, 32'd0);
        check("exit halt", halt, 1);
        check("exit busy", busy, 0);
        b0 = busyCnt;
        b1 = txLowCnt;
        b2 = badCnt;
        cs0 = int'(chars_sent);
        request(32'd11, 32'h41);
        repeat (60) @(negedge clk);
        check("halted tx", txLowCnt - b1, 0);
        check("halted busy", busyCnt - b0, 0);
        check("halted bad_code", badCnt - b2, 0);
        check("halted chars_sent", int'(chars_sent), cs0);
        check("halt sticky", halt, 1);
        check("framing errors", rxFrameErr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
